swd_xact_ctrl: RTL and testbench

- Transaction sequencer for the SWD PHY.
- Accepts one DP/AP register access at a time, encodes it as a PHY command word {LEN, T0, T1, SO}, and pushes it into the PHY input FIFO.
- Pops the PHY response word, decodes ACK, data and parity, retries on WAIT, and returns a status/data response to the bus-bridge side.
- Also issues line-reset sequences on request.

---
 rtl/swd_xact_if.sv | 42 ++++
 rtl/swd_xact_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_swd_xact_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/swd_xact_if.sv
// Bus-bridge request/response and PHY FIFO signals for the SWD transaction sequencer.
// slave = sequencer view, master = bridge/PHY environment view.
interface swd_xact_if #(
   parameter int OWIDTH = 64,
   parameter int IWIDTH = 38
);
   localparam int LW = $clog2(OWIDTH);
   localparam int CW = $clog2(IWIDTH);

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_linerst;
   logic                     req_apndp;
   logic                     req_rnw;
   logic [1:0]               req_addr;
   logic [31:0]              req_wdata;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [2:0]               rsp_stat;
   logic [2:0]               rsp_ack;
   logic [31:0]              rsp_rdata;
   logic [OWIDTH+3*LW-1:0]   phy_wrdata;
   logic                     phy_wren;
   logic                     phy_wrfull;
   logic [IWIDTH+CW-2:0]     phy_rddata;
   logic                     phy_rden;
   logic                     phy_rdempty;

   modport slave (
      input  req_valid, req_linerst, req_apndp, req_rnw, req_addr, req_wdata,
      input  rsp_ready, phy_wrfull, phy_rddata, phy_rdempty,
      output req_ready, rsp_valid, rsp_stat, rsp_ack, rsp_rdata,
      output phy_wrdata, phy_wren, phy_rden
   );

   modport master (
      output req_valid, req_linerst, req_apndp, req_rnw, req_addr, req_wdata,
      output rsp_ready, phy_wrfull, phy_rddata, phy_rdempty,
      input  req_ready, rsp_valid, rsp_stat, rsp_ack, rsp_rdata,
      input  phy_wrdata, phy_wren, phy_rden
   );
endinterface

// File: rtl/swd_xact_ctrl.sv
// SWD transaction sequencer: encodes one DP/AP access or line reset into a PHY command
// word, retries on WAIT, decodes the captured response and returns status/data.
//
// state      | meaning
// IDLE       | ready for a request
// ISSUE      | push the command word once the PHY input FIFO has room
// RSP_WAIT   | wait for a PHY response word, bounded by the timeout counter
// CAPTURE    | register the popped response word
// EVAL       | decode ACK / cnt / parity, retry or respond
// RESP       | hold the response until the bridge consumes it
module swd_xact_ctrl #(
   parameter int OWIDTH    = 64,
   parameter int IWIDTH    = 38,
   parameter int RETRY_MAX = 255,
   parameter int TIMEOUT   = 4095
) (
   input  logic        clk,
   input  logic        reset,
   swd_xact_if.slave   bus
);
   localparam int LW = $clog2(OWIDTH);
   localparam int CW = $clog2(IWIDTH);
   localparam int WW = OWIDTH + 3*LW;
   localparam int RW = $clog2(RETRY_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_RSP_WAIT = 3'd2;
   localparam logic [2:0] S_CAPTURE  = 3'd3;
   localparam logic [2:0] S_EVAL     = 3'd4;
   localparam logic [2:0] S_RESP     = 3'd5;

   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;

   localparam logic [2:0] ST_OK     = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_FAULT  = 3'd2;
   localparam logic [2:0] ST_PROTO  = 3'd3;
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic [2:0] ST_TMO    = 3'd5;

   localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
   localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT);

   logic [2:0]           state;
   logic                 linerst_q;
   logic                 rnw_q;
   logic [WW-1:0]        cmd_q;
   logic [WW-1:0]        cmd_enc;
   logic [IWIDTH+CW-2:0] cap_q;
   logic [RW-1:0]        retry_cnt;
   logic [TW-1:0]        tmo_cnt;
   logic                 req_ready_q;
   logic                 rsp_valid_q;
   logic [2:0]           stat_q;
   logic [2:0]           ack_q;
   logic [31:0]          rdata_q;

   logic [7:0]           hdr;
   logic [OWIDTH-1:0]    so;
   logic [IWIDTH-2:0]    si;
   logic [CW-1:0]        cnt;
   logic [2:0]           ack_raw;
   logic [31:0]          rd_data;
   logic                 rd_par_ok;
   logic [2:0]           eval_stat;
   logic                 si_unused;

   always_comb begin
      hdr = {1'b1, 1'b0, ^{bus.req_apndp, bus.req_rnw, bus.req_addr},
             bus.req_addr, bus.req_rnw, bus.req_apndp, 1'b1};
      so      = '0;
      cmd_enc = '0;
      if (bus.req_linerst) begin
         so[49:0] = '1;
         cmd_enc  = {LW'(58), LW'(63), LW'(63), so};
      end else if (bus.req_rnw) begin
         so[7:0] = hdr;
         cmd_enc = {LW'(46), LW'(8), LW'(45), so};
      end else begin
         so[7:0]   = hdr;
         so[44:13] = bus.req_wdata;
         so[45]    = ^bus.req_wdata;
         cmd_enc   = {LW'(46), LW'(8), LW'(13), so};
      end
   end

   // si[cnt-1] arrived first, so fields read MSB-down from the top valid bit.
   assign si        = cap_q[IWIDTH+CW-2:CW];
   assign cnt       = cap_q[CW-1:0];
   assign si_unused = si[IWIDTH-2];

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 32; i++) rd_data[i] = si[32-i];
      rd_par_ok = ((^rd_data) == si[0]);
      ack_raw   = rnw_q ? {si[33], si[34], si[35]} : {si[0], si[1], si[2]};
      eval_stat = ST_OK;
      if (!rnw_q && cnt != CW'(3)) begin
         eval_stat = ST_PROTO;
      end else begin
         case (ack_raw)
            ACK_OK: begin
               if (rnw_q && cnt != CW'(36))  eval_stat = ST_PROTO;
               else if (rnw_q && !rd_par_ok) eval_stat = ST_PARITY;
               else                          eval_stat = ST_OK;
            end
            ACK_WAIT:  eval_stat = ST_WAIT;
            ACK_FAULT: eval_stat = ST_FAULT;
            default:   eval_stat = ST_PROTO;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         linerst_q   <= 1'b0;
         rnw_q       <= 1'b0;
         cmd_q       <= '0;
         cap_q       <= '0;
         retry_cnt   <= '0;
         tmo_cnt     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         stat_q      <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  cmd_q       <= cmd_enc;
                  linerst_q   <= bus.req_linerst;
                  rnw_q       <= bus.req_rnw & ~bus.req_linerst;
                  retry_cnt   <= '0;
                  req_ready_q <= 1'b0;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!bus.phy_wrfull) begin
                  if (linerst_q) begin
                     state       <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     stat_q      <= ST_OK;
                     ack_q       <= '0;
                     rdata_q     <= '0;
                  end else begin
                     state   <= S_RSP_WAIT;
                     tmo_cnt <= '0;
                  end
               end
            end
            S_RSP_WAIT: begin
               if (!bus.phy_rdempty) begin
                  state <= S_CAPTURE;
               end else if (tmo_cnt == TMO_LIM) begin
                  state       <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  stat_q      <= ST_TMO;
                  ack_q       <= '0;
                  rdata_q     <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               cap_q <= bus.phy_rddata;
               state <= S_EVAL;
            end
            S_EVAL: begin
               if (eval_stat == ST_WAIT && retry_cnt < RETRY_LIM) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= S_ISSUE;
               end else begin
                  state       <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  stat_q      <= eval_stat;
                  ack_q       <= ack_raw;
                  rdata_q     <= (rnw_q && eval_stat == ST_OK) ? rd_data : 32'h0;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_stat   = stat_q;
   assign bus.rsp_ack    = ack_q;
   assign bus.rsp_rdata  = rdata_q;
   assign bus.phy_wrdata = cmd_q;
   assign bus.phy_wren   = (state == S_ISSUE) && !bus.phy_wrfull;
   assign bus.phy_rden   = (state == S_RSP_WAIT) && !bus.phy_rdempty;
endmodule

// File: tb/tb_swd_xact_ctrl.sv
// Scoreboard bench for swd_xact_ctrl with a small PHY FIFO model.
module tb_swd_xact_ctrl;
   localparam int OWIDTH = 64, IWIDTH = 38, RETRY_MAX = 2, TIMEOUT = 15;
   localparam int WW = OWIDTH + 3*6;
   localparam int RDW = IWIDTH + 6 - 1;

   typedef struct packed {
      logic [2:0]  stat;
      logic [2:0]  ack;
      logic [31:0] rdata;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   swd_xact_if #(.OWIDTH(OWIDTH), .IWIDTH(IWIDTH)) bus ();

   swd_xact_ctrl #(.OWIDTH(OWIDTH), .IWIDTH(IWIDTH), .RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rsp_t            exp_rsp_q[$];
   logic [WW-1:0]   exp_cmd_q[$];
   logic [RDW-1:0]  plan_q[$];
   logic [RDW-1:0]  fifo_q[$];
   int              n_chk = 0, n_pass = 0;
   int              wren_cnt = 0, rden_cnt = 0;
   int              cyc = 0, wren_cyc = 0, rspv_cyc = 0;
   logic            prev_rspv = 1'b0;
   logic            pop_f = 1'b0, push_f = 1'b0;
   logic [RDW-1:0]  push_w = '0;
   logic [WW-1:0]   last_wr = '0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [WW-1:0] cmd_m(input logic lr, input logic apndp, input logic rnw,
                                          input logic [1:0] a, input logic [31:0] wdata);
      logic [63:0] so;
      logic [5:0]  len, t0, t1;
      so = '0;
      if (lr) begin
         for (int i = 0; i < 50; i++) so[i] = 1'b1;
         len = 6'd58; t0 = 6'd63; t1 = 6'd63;
      end else begin
         so[0] = 1'b1; so[1] = apndp; so[2] = rnw; so[3] = a[0]; so[4] = a[1];
         so[5] = apndp ^ rnw ^ a[0] ^ a[1]; so[6] = 1'b0; so[7] = 1'b1;
         len = 6'd46; t0 = 6'd8;
         if (rnw) t1 = 6'd45;
         else begin
            t1 = 6'd13;
            for (int i = 0; i < 32; i++) so[13+i] = wdata[i];
            so[45] = ^wdata;
         end
      end
      return {len, t0, t1, so};
   endfunction

   function automatic logic [RDW-1:0] rd_reply(input logic [2:0] ack, input logic [31:0] data,
                                              input logic flip, input int cnt);
      logic [36:0] si;
      si = '0;
      for (int k = 0; k < 3; k++) si[35-k] = ack[k];
      for (int i = 0; i < 32; i++) si[32-i] = data[i];
      si[0] = (^data) ^ flip;
      return {si, 6'(cnt)};
   endfunction

   function automatic logic [RDW-1:0] wr_reply(input logic [2:0] ack);
      logic [36:0] si;
      si = '0;
      for (int k = 0; k < 3; k++) si[2-k] = ack[k];
      return {si, 6'd3};
   endfunction

   // PHY FIFO model: pops/pushes decided on the negedge, applied on the posedge
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         fifo_q.delete();
         bus.phy_rdempty <= 1'b1;
         bus.phy_rddata  <= '0;
      end else begin
         if (pop_f) bus.phy_rddata <= fifo_q.pop_front();
         if (push_f) fifo_q.push_back(push_w);
         bus.phy_rdempty <= (fifo_q.size() == 0);
      end
   end

   always @(negedge clk) begin
      rsp_t e;
      pop_f  = bus.phy_rden;
      push_f = 1'b0;
      if (!reset) begin
         if (bus.phy_wren) begin
            wren_cnt++;
            wren_cyc = cyc;
            last_wr  = bus.phy_wrdata;
            if (exp_cmd_q.size() > 0) chk("wrdata", bus.phy_wrdata, exp_cmd_q[0]);
            else chk("wren_unexpected", exp_cmd_q.size(), 1);
            if (plan_q.size() > 0) begin
               push_f = 1'b1;
               push_w = plan_q.pop_front();
            end
         end
         if (bus.phy_rden) rden_cnt++;
         if (bus.rsp_valid && !prev_rspv) rspv_cyc = cyc;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp_q.size() > 0) begin
               e = exp_rsp_q.pop_front();
               chk("rsp_stat", bus.rsp_stat, e.stat);
               chk("rsp_ack", bus.rsp_ack, e.ack);
               chk("rsp_rdata", bus.rsp_rdata, e.rdata);
               if (exp_cmd_q.size() > 0) void'(exp_cmd_q.pop_front());
            end else begin
               chk("rsp_unexpected", exp_rsp_q.size(), 1);
            end
         end
      end
      prev_rspv = bus.rsp_valid;
   end

   task automatic send(input logic lr, input logic apndp, input logic rnw,
                       input logic [1:0] a, input logic [31:0] wdata);
      int n;
      bus.req_valid   = 1'b1;
      bus.req_linerst = lr;
      bus.req_apndp   = apndp;
      bus.req_rnw     = rnw;
      bus.req_addr    = a;
      bus.req_wdata   = wdata;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", bus.req_ready, 1'b1);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (exp_rsp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, exp_rsp_q.size(), 0);
   endtask

   task automatic xact(input logic lr, input logic apndp, input logic rnw, input logic [1:0] a,
                       input logic [31:0] wdata, input logic [2:0] stat, input logic [2:0] ack,
                       input logic [31:0] rdata, input string tag);
      rsp_t r;
      r.stat = stat; r.ack = ack; r.rdata = rdata;
      exp_cmd_q.push_back(cmd_m(lr, apndp, rnw, a, wdata));
      exp_rsp_q.push_back(r);
      send(lr, apndp, rnw, a, wdata);
      wait_rsp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_wr, snap_rd, n;
      bus.req_valid = 1'b0; bus.req_linerst = 1'b0; bus.req_apndp = 1'b0;
      bus.req_rnw = 1'b0; bus.req_addr = 2'b00; bus.req_wdata = '0;
      bus.rsp_ready = 1'b1; bus.phy_wrfull = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_wren", bus.phy_wren, 1'b0);
      chk("rst_wrdata", bus.phy_wrdata, '0);
      reset = 1'b0;
      @(negedge clk);
      chk("req_ready_after_rst", bus.req_ready, 1'b1);

      // DP write, A=01
      plan_q.push_back(wr_reply(3'b001));
      xact(0, 0, 0, 2'b01, 32'hDEADBEEF, 3'd0, 3'b001, 32'h0, "wr_ok");
      chk("wr_len", last_wr[81:76], 6'd46);
      chk("wr_t0", last_wr[75:70], 6'd8);
      chk("wr_t1", last_wr[69:64], 6'd13);
      chk("wr_hdr", last_wr[7:0], 8'hA9);
      chk("wr_par", last_wr[45], 1'b0);

      // AP reads A=11: good, bad parity, bad ACK, bad cnt
      plan_q.push_back(rd_reply(3'b001, 32'h12345678, 1'b0, 36));
      xact(0, 1, 1, 2'b11, 0, 3'd0, 3'b001, 32'h12345678, "rd_ok");
      chk("rd_t1", last_wr[69:64], 6'd45);
      plan_q.push_back(rd_reply(3'b001, 32'h12345678, 1'b1, 36));
      xact(0, 1, 1, 2'b11, 0, 3'd4, 3'b001, 32'h0, "rd_parity");
      plan_q.push_back(rd_reply(3'b111, 32'h12345678, 1'b0, 36));
      xact(0, 1, 1, 2'b11, 0, 3'd3, 3'b111, 32'h0, "rd_badack");
      plan_q.push_back(rd_reply(3'b001, 32'h12345678, 1'b0, 35));
      xact(0, 1, 1, 2'b11, 0, 3'd3, 3'b001, 32'h0, "rd_badcnt");
      plan_q.push_back(wr_reply(3'b100));
      xact(0, 1, 0, 2'b10, 32'h0000_00F0, 3'd2, 3'b100, 32'h0, "wr_fault");

      // WAIT exhausts after RETRY_MAX retries
      snap_wr = wren_cnt;
      repeat (3) plan_q.push_back(wr_reply(3'b010));
      xact(0, 0, 0, 2'b00, 32'h5555AAAA, 3'd1, 3'b010, 32'h0, "wr_wait");
      chk("wait_wren_pulses", wren_cnt - snap_wr, 3);

      // one WAIT then OK: retry count starts fresh per request
      snap_wr = wren_cnt;
      plan_q.push_back(rd_reply(3'b010, 32'h0, 1'b0, 36));
      plan_q.push_back(rd_reply(3'b001, 32'h80000001, 1'b0, 36));
      xact(0, 0, 1, 2'b00, 0, 3'd0, 3'b001, 32'h80000001, "rd_retry_ok");
      chk("retry_wren_pulses", wren_cnt - snap_wr, 2);

      // line reset behind a full PHY FIFO
      bus.phy_wrfull = 1'b1;
      snap_wr = wren_cnt;
      snap_rd = rden_cnt;
      exp_cmd_q.push_back(cmd_m(1, 0, 0, 2'b00, 0));
      exp_rsp_q.push_back('{stat: 3'd0, ack: 3'b000, rdata: 32'h0});
      send(1, 0, 0, 2'b00, 0);
      repeat (10) @(negedge clk);
      chk("lr_no_wren_full", wren_cnt - snap_wr, 0);
      bus.phy_wrfull = 1'b0;
      wait_rsp("lr_done");
      chk("lr_wren_pulses", wren_cnt - snap_wr, 1);
      chk("lr_no_rden", rden_cnt - snap_rd, 0);
      chk("lr_len", last_wr[81:76], 6'd58);
      chk("lr_ones", last_wr[49:0], {50{1'b1}});

      // no PHY response: timeout after TIMEOUT+1 cycles in RSP_WAIT
      snap_rd = rden_cnt;
      xact(0, 1, 1, 2'b01, 0, 3'd5, 3'b000, 32'h0, "rd_timeout");
      chk("tmo_latency", rspv_cyc - wren_cyc, TIMEOUT + 2);
      chk("tmo_no_rden", rden_cnt - snap_rd, 0);

      // reset while the response is held
      bus.rsp_ready = 1'b0;
      plan_q.push_back(wr_reply(3'b001));
      exp_cmd_q.push_back(cmd_m(0, 0, 0, 2'b11, 32'h0BADF00D));
      send(0, 0, 0, 2'b11, 32'h0BADF00D);
      n = 0;
      while (!bus.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("resp_held", bus.rsp_valid, 1'b1);
      chk("resp_held_stat", bus.rsp_stat, 3'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_drop_valid", bus.rsp_valid, 1'b0);
      chk("rst_ready_low", bus.req_ready, 1'b0);
      reset = 1'b0;
      exp_cmd_q.delete();
      @(negedge clk);
      chk("rst_ready_back", bus.req_ready, 1'b1);
      bus.rsp_ready = 1'b1;

      plan_q.push_back(rd_reply(3'b001, 32'hCAFE0001, 1'b0, 36));
      xact(0, 0, 1, 2'b10, 0, 3'd0, 3'b001, 32'hCAFE0001, "rd_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
